boreal_mailbox_ctrl: RTL and testbench

Command sequencer for the dual-port mailbox's internal ports. On a doorbell it streams a block of mailbox words through read port A and forms a 32-bit wrapping sum. It then writes the sum and a status word back through write port B and pulses completion. It sits between the MMIO doorbell decode and the mailbox; the CPU port of the mailbox is untouched.

---
 rtl/boreal_mailbox_ctrl.sv | 168 ++++++++++++++++
 tb/tb_boreal_mailbox_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_mailbox_ctrl.sv
// Mailbox command sequencer: on a doorbell, sums a block of mailbox words read
// through port A, then writes the sum and a status word through port B.
module boreal_mailbox_ctrl #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               db_valid,
  output logic               db_ready,
  input  logic [IDX_W-1:0]   db_src,
  input  logic [IDX_W:0]     db_len,
  input  logic [IDX_W-1:0]   db_dst,
  output logic [IDX_W-1:0]   a_ridx,
  input  logic [31:0]        a_rdata,
  output logic               b_we,
  output logic [IDX_W-1:0]   b_widx,
  output logic [31:0]        b_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   cmd_count
);

  localparam int unsigned LEN_W      = IDX_W + 1;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MAX_LEN    = 1 << IDX_W;
  localparam int unsigned STAT_CNT_W = DATA_W - 7 - LEN_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WR_SUM,
    S_WR_STAT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                pv_q, pv_d;
  logic                rej_q, rej_d;
  logic [IDX_W-1:0]    a_ridx_d;
  logic                b_we_d;
  logic [IDX_W-1:0]    b_widx_d;
  logic [DATA_W-1:0]   b_wdata_d;
  logic                busy_d, done_d, err_d, db_ready_d;
  logic [CNT_W-1:0]    cmd_count_d;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      len_q     <= '0;
      dst_q     <= '0;
      sum_q     <= '0;
      pv_q      <= 1'b0;
      rej_q     <= 1'b0;
      a_ridx    <= '0;
      b_we      <= 1'b0;
      b_widx    <= '0;
      b_wdata   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      db_ready  <= 1'b1;
      cmd_count <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      dst_q     <= dst_d;
      sum_q     <= sum_d;
      pv_q      <= pv_d;
      rej_q     <= rej_d;
      a_ridx    <= a_ridx_d;
      b_we      <= b_we_d;
      b_widx    <= b_widx_d;
      b_wdata   <= b_wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      db_ready  <= db_ready_d;
      cmd_count <= cmd_count_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with it
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    len_d       = len_q;
    dst_d       = dst_q;
    sum_d       = pv_q ? (sum_q + a_rdata) : sum_q;
    pv_d        = (state_q == S_READ);
    rej_d       = rej_q;
    a_ridx_d    = a_ridx;
    b_we_d      = 1'b0;
    b_widx_d    = b_widx;
    b_wdata_d   = b_wdata;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_count_d = cmd_count;

    case (state_q)
      S_IDLE: begin
        if (db_valid) begin
          len_d = db_len;
          rem_d = db_len;
          dst_d = db_dst;
          sum_d = '0;
          rej_d = 1'b0;
          if (db_len > LEN_W'(MAX_LEN)) begin
            rej_d   = 1'b1;
            state_d = S_DONE;
          end else if (db_len == '0) begin
            state_d = S_WR_SUM;
          end else begin
            a_ridx_d = db_src;
            state_d  = S_READ;
          end
        end
      end
      S_READ: begin
        if (rem_q == LEN_W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          rem_d    = rem_q - LEN_W'(1);
          a_ridx_d = a_ridx + IDX_W'(1);
        end
      end
      S_DRAIN:   state_d = S_WR_SUM;
      S_WR_SUM:  state_d = S_WR_STAT;
      S_WR_STAT: begin
        cmd_count_d = cmd_count + CNT_W'(1);
        state_d     = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_SUM: begin
        b_we_d    = 1'b1;
        b_widx_d  = dst_d;
        b_wdata_d = sum_d;
      end
      S_WR_STAT: begin
        b_we_d    = 1'b1;
        b_widx_d  = dst_q + IDX_W'(1);
        b_wdata_d = {STAT_CNT_W'(cmd_count + CNT_W'(1)), 7'd0, len_q};
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = rej_d;
      end
      default: ;
    endcase

    busy_d     = (state_d != S_IDLE);
    db_ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_boreal_mailbox_ctrl.sv
// Self-checking bench for boreal_mailbox_ctrl with a behavioural mailbox model.
module tb_boreal_mailbox_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        db_valid;
  logic        db_ready;
  logic [7:0]  db_src;
  logic [8:0]  db_len;
  logic [7:0]  db_dst;
  logic [7:0]  a_ridx;
  logic [31:0] a_rdata;
  logic        b_we;
  logic [7:0]  b_widx;
  logic [31:0] b_wdata;
  logic        busy, done, err;
  logic [15:0] cmd_count;

  logic        cpu_we;
  logic [7:0]  cpu_idx;
  logic [31:0] cpu_data;
  logic [31:0] mem [256];

  int n_pass = 0;
  int n_total = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  boreal_mailbox_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .db_valid(db_valid), .db_ready(db_ready),
    .db_src(db_src), .db_len(db_len), .db_dst(db_dst),
    .a_ridx(a_ridx), .a_rdata(a_rdata),
    .b_we(b_we), .b_widx(b_widx), .b_wdata(b_wdata),
    .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
  );

  // Mailbox: synchronous read on port A; CPU write then port B write (B wins)
  always @(posedge clk) begin
    a_rdata <= mem[a_ridx];
    if (cpu_we) mem[cpu_idx] <= cpu_data;
    if (b_we)   mem[b_widx]  <= b_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cpu_write(input logic [7:0] idx, input logic [31:0] data);
    cpu_we = 1'b1; cpu_idx = idx; cpu_data = data;
    @(posedge clk);
    #1 cpu_we = 1'b0;
  endtask

  // Issue one command and check it against the reference rules
  task automatic run_cmd(input logic [7:0] src, input logic [8:0] len, input logic [7:0] dst,
                         output int lat, output logic err_o);
    logic [31:0] exp_sum;
    logic [31:0] exp_stat;
    logic [7:0]  widx [$];
    logic [31:0] wdat [$];
    logic        valid;
    int          exp_lat, k_done, busy_n, ridx_bad;
    @(negedge clk);
    check("ready_idle", 32'(db_ready), 32'd1);
    valid   = (len <= 9'd256);
    exp_sum = 32'd0;
    if (valid) for (int i = 0; i < int'(len); i++) exp_sum += mem[8'(int'(src) + i)];
    exp_lat  = !valid ? 1 : ((len == 9'd0) ? 3 : int'(len) + 4);
    exp_stat = {16'(model_count + 1), 7'd0, len};
    db_valid = 1'b1; db_src = src; db_len = len; db_dst = dst;
    @(posedge clk);
    #1 db_valid = 1'b0;
    k_done = 0; busy_n = 0; ridx_bad = 0; err_o = 1'b0;
    for (int k = 1; k <= 600 && k_done == 0; k++) begin
      @(negedge clk);
      if (b_we) begin widx.push_back(b_widx); wdat.push_back(b_wdata); end
      if (busy) busy_n++;
      if (valid && k <= int'(len) && a_ridx != 8'(int'(src) + k - 1)) ridx_bad++;
      if (done) begin k_done = k; err_o = err; end
    end
    lat = k_done;
    if (k_done == 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_latency", 32'(k_done), 32'(exp_lat));
      check("err_flag", 32'(err_o), 32'(!valid));
      check("busy_cycles", 32'(busy_n), 32'(exp_lat));
      check("write_count", 32'(widx.size()), valid ? 32'd2 : 32'd0);
      check("ridx_sequence_bad", 32'(ridx_bad), 32'd0);
      if (valid && widx.size() == 2) begin
        check("sum_idx", 32'(widx[0]), 32'(dst));
        check("sum_data", wdat[0], exp_sum);
        check("stat_idx", 32'(widx[1]), 32'(8'(dst + 8'd1)));
        check("stat_data", wdat[1], exp_stat);
      end
    end
    if (valid) model_count++;
    check("cmd_count", 32'(cmd_count), 32'(16'(model_count)));
  endtask

  typedef struct {
    logic [7:0] src;
    logic [8:0] len;
    logic [7:0] dst;
    int         exp_lat;
    logic       exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nr, nb, dk, nwe, nd;
    logic e;
    vecs[0] = '{src: 8'd5,   len: 9'd1,   dst: 8'd200, exp_lat: 5,   exp_err: 1'b0};
    vecs[1] = '{src: 8'd0,   len: 9'd256, dst: 8'd30,  exp_lat: 260, exp_err: 1'b0};
    vecs[2] = '{src: 8'd100, len: 9'd257, dst: 8'd7,   exp_lat: 1,   exp_err: 1'b1};
    vecs[3] = '{src: 8'd50,  len: 9'd511, dst: 8'd7,   exp_lat: 1,   exp_err: 1'b1};
    vecs[4] = '{src: 8'd20,  len: 9'd2,   dst: 8'd21,  exp_lat: 6,   exp_err: 1'b0};
    vecs[5] = '{src: 8'd0,   len: 9'd0,   dst: 8'd0,   exp_lat: 3,   exp_err: 1'b0};

    rst_n = 1'b0; db_valid = 1'b0; db_src = '0; db_len = '0; db_dst = '0;
    cpu_we = 1'b0; cpu_idx = '0; cpu_data = '0;
    #12;
    check("rst_db_ready", 32'(db_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_b_we", 32'(b_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cmd_count", 32'(cmd_count), 32'd0);
    check("rst_a_ridx", 32'(a_ridx), 32'd0);
    check("rst_b_wdata", b_wdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(db_ready), 32'd1);

    for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom);

    // Basic sum of 1..4
    for (int i = 0; i < 4; i++) cpu_write(8'(i), 32'(i + 1));
    run_cmd(8'd0, 9'd4, 8'd16, lat, e);
    check("basic_lat", 32'(lat), 32'd8);
    check("basic_word16", mem[16], 32'd10);
    check("basic_word17", mem[17], 32'h0001_0004);
    check("basic_count", 32'(cmd_count), 32'd1);

    // Index wrap and 32-bit sum wrap
    cpu_write(8'd254, 32'hFFFF_FFFF);
    cpu_write(8'd255, 32'd1);
    cpu_write(8'd0, 32'd5);
    cpu_write(8'd1, 32'd6);
    run_cmd(8'd254, 9'd4, 8'd40, lat, e);
    check("wrap_sum", mem[40], 32'd11);

    // Zero length, status word wraps to index 0
    run_cmd(8'd0, 9'd0, 8'd255, lat, e);
    check("zero_lat", 32'(lat), 32'd3);
    check("zero_word255", mem[255], 32'd0);
    check("zero_word0", mem[0], 32'h0003_0000);

    // Rejected length, then an immediately following command
    run_cmd(8'd9, 9'd300, 8'd60, lat, e);
    check("rej_lat", 32'(lat), 32'd1);
    check("rej_err", 32'(e), 32'd1);
    check("rej_count", 32'(cmd_count), 32'd3);
    run_cmd(8'd12, 9'd3, 8'd61, lat, e);
    check("after_rej_lat", 32'(lat), 32'd7);

    // Table of boundary vectors
    for (int v = 0; v < 6; v++) begin
      run_cmd(vecs[v].src, vecs[v].len, vecs[v].dst, lat, e);
      check($sformatf("tbl%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("tbl%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
    end

    // db_valid held high through a len=8 command
    @(negedge clk);
    check("hold_ready0", 32'(db_ready), 32'd1);
    db_valid = 1'b1; db_src = 8'd8; db_len = 9'd8; db_dst = 8'd70;
    @(posedge clk);
    #1 db_src = 8'd100; db_len = 9'd2; db_dst = 8'd90;
    nr = 0; nb = 0; dk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!db_ready) nr++;
      if (busy) nb++;
      if (done) dk = k;
    end
    check("hold_ready_low", 32'(nr), 32'd12);
    check("hold_busy_high", 32'(nb), 32'd12);
    check("hold_done_cycle", 32'(dk), 32'd12);
    @(negedge clk);
    check("hold_idle_ready", 32'(db_ready), 32'd1);
    check("hold_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 db_valid = 1'b0;
    @(negedge clk);
    check("hold_second_busy", 32'(busy), 32'd1);
    dk = 0;
    for (int k = 2; k <= 20 && dk == 0; k++) begin
      @(negedge clk);
      if (done) dk = k;
    end
    check("hold_second_done", 32'(dk), 32'd6);
    model_count += 2;
    check("hold_count", 32'(cmd_count), 32'(16'(model_count)));

    // Randomized commands against the reference rules
    for (int r = 0; r < 40; r++) begin
      logic [8:0] rl;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) rl = 9'($urandom_range(257, 511));
      else if ($urandom_range(0, 19) == 0) rl = 9'd256;
      else rl = 9'($urandom_range(0, 40));
      run_cmd(8'($urandom), rl, 8'($urandom), lat, e);
    end

    // Reset in the middle of a long read
    @(negedge clk);
    db_valid = 1'b1; db_src = 8'd0; db_len = 9'd200; db_dst = 8'd50;
    @(posedge clk);
    #1 db_valid = 1'b0;
    nwe = 0; nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (b_we) nwe++;
      if (done) nd++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_b_we", 32'(b_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(cmd_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (b_we) nwe++;
      if (done) nd++;
    end
    check("midrst_no_write", 32'(nwe), 32'd0);
    check("midrst_no_done", 32'(nd), 32'd0);
    check("midrst_ready", 32'(db_ready), 32'd1);
    model_count = 0;
    run_cmd(8'd3, 9'd3, 8'd60, lat, e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
